// File: rtl/branch_resolve_unit.sv
// Branch resolution in ID: checks conditional-branch predictions against the real
// operands, issues a one-cycle redirect/flush on a miss, and feeds outcomes back to the predictor.
module branch_resolve_unit #(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic                id_stall,
    input  logic [5:0]          id_op,
    input  logic [31:0]         id_rs_val,
    input  logic [31:0]         id_rt_val,
    input  logic [31:0]         id_pc4,
    input  logic [15:0]         id_imm,
    input  logic                id_pred_taken,
    input  logic [IDX_BITS-1:0] id_pred_idx,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    output logic                flush,
    output logic                upd_valid,
    input  logic                upd_ready,
    output logic [IDX_BITS-1:0] upd_idx,
    output logic                upd_taken,
    output logic [CNT_W-1:0]    branch_cnt,
    output logic [CNT_W-1:0]    mispredict_cnt,
    output logic [CNT_W-1:0]    upd_drop_cnt
);

    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BGTZ = 6'd7;

    logic        accept;
    logic        is_cond;
    logic        resolve;
    logic        actual_taken;
    logic        mispredict;
    logic [31:0] target;
    logic [31:0] fix_pc;

    // Redirect state
    logic        redirect_q;
    logic [31:0] redirect_pc_q;

    // Update FIFO state
    logic [IDX_BITS-1:0] fifo_idx [2];
    logic                fifo_tkn [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          count;
    logic                fifo_full;
    logic                deq;
    logic                enq;
    logic                drop;

    // An instruction sitting in ID during a flush is wrong-path and must be ignored.
    assign accept = id_valid & ~id_stall & ~redirect_q;

    always_comb begin
        is_cond = 1'b0;
        case (id_op)
            OP_BEQ, OP_BNE, OP_BGTZ: is_cond = 1'b1;
            default:                 is_cond = 1'b0;
        endcase
    end

    always_comb begin
        actual_taken = 1'b0;
        case (id_op)
            OP_BEQ:  actual_taken = (id_rs_val == id_rt_val);
            OP_BNE:  actual_taken = (id_rs_val != id_rt_val);
            OP_BGTZ: actual_taken = ~id_rs_val[31] & (id_rs_val != 32'd0);
            default: actual_taken = 1'b0;
        endcase
    end

    assign resolve    = accept & is_cond;
    assign mispredict = resolve & (id_pred_taken != actual_taken);
    assign target     = id_pc4 + {{14{id_imm[15]}}, id_imm, 2'b00};
    assign fix_pc     = actual_taken ? target : id_pc4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            redirect_q <= mispredict;
            if (mispredict)
                redirect_pc_q <= fix_pc;
        end
    end

    assign redirect_valid = redirect_q;
    assign flush          = redirect_q;
    assign redirect_pc    = redirect_pc_q;

    // A full FIFO still takes a new entry when its head leaves in the same cycle;
    // in that case wr_ptr equals rd_ptr, so the new entry lands in the freed slot.
    assign fifo_full = (count == 2'd2);
    assign deq       = upd_valid & upd_ready;
    assign enq       = resolve & (~fifo_full | deq);
    assign drop      = resolve & fifo_full & ~deq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_idx[0] <= '0;
            fifo_idx[1] <= '0;
            fifo_tkn[0] <= 1'b0;
            fifo_tkn[1] <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (enq) begin
                fifo_idx[wr_ptr] <= id_pred_idx;
                fifo_tkn[wr_ptr] <= actual_taken;
                wr_ptr           <= ~wr_ptr;
            end
            if (deq)
                rd_ptr <= ~rd_ptr;
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign upd_valid = (count != 2'd0);
    assign upd_idx   = upd_valid ? fifo_idx[rd_ptr] : '0;
    assign upd_taken = upd_valid & fifo_tkn[rd_ptr];

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
            upd_drop_cnt   <= '0;
        end else begin
            if (resolve && (branch_cnt != '1))
                branch_cnt <= branch_cnt + 1'b1;
            if (mispredict && (mispredict_cnt != '1))
                mispredict_cnt <= mispredict_cnt + 1'b1;
            if (drop && (upd_drop_cnt != '1))
                upd_drop_cnt <= upd_drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit: vector table for single resolutions
// plus hand sequences for flush shadow, stall, FIFO full/drop, saturation and reset.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_stall;
    logic [5:0]  id_op;
    logic [31:0] id_rs_val, id_rt_val, id_pc4;
    logic [15:0] id_imm;
    logic        id_pred_taken;
    logic [5:0]  id_pred_idx;
    logic        redirect_valid, flush, upd_valid, upd_ready, upd_taken;
    logic [31:0] redirect_pc;
    logic [5:0]  upd_idx;
    logic [31:0] branch_cnt, mispredict_cnt, upd_drop_cnt;

    logic        s_redirect_valid, s_flush, s_upd_valid, s_upd_taken;
    logic [31:0] s_redirect_pc;
    logic [5:0]  s_upd_idx;
    logic [1:0]  s_branch_cnt, s_mispredict_cnt, s_upd_drop_cnt;

    int checks = 0;
    int errors = 0;
    int bc = 0, mc = 0, dc = 0;
    logic [31:0] last_pc = 32'd0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.IDX_BITS(6), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_stall(id_stall),
        .id_op(id_op), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_pc4(id_pc4), .id_imm(id_imm), .id_pred_taken(id_pred_taken),
        .id_pred_idx(id_pred_idx), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .upd_valid(upd_valid),
        .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt),
        .upd_drop_cnt(upd_drop_cnt)
    );

    // Narrow-counter copy used only to observe saturation.
    branch_resolve_unit #(.IDX_BITS(6), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_stall(id_stall),
        .id_op(id_op), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_pc4(id_pc4), .id_imm(id_imm), .id_pred_taken(id_pred_taken),
        .id_pred_idx(id_pred_idx), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .flush(s_flush), .upd_valid(s_upd_valid),
        .upd_ready(upd_ready), .upd_idx(s_upd_idx), .upd_taken(s_upd_taken),
        .branch_cnt(s_branch_cnt), .mispredict_cnt(s_mispredict_cnt),
        .upd_drop_cnt(s_upd_drop_cnt)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pc4;
        logic [15:0] imm;
        logic        pred;
        logic [5:0]  idx;
        logic        cond;
        logic        taken;
        logic        redir;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pc4, input logic [15:0] imm, input logic pred,
                         input logic [5:0] idx);
        id_valid      = 1'b1;
        id_op         = op;
        id_rs_val     = rs;
        id_rt_val     = rt;
        id_pc4        = pc4;
        id_imm        = imm;
        id_pred_taken = pred;
        id_pred_idx   = idx;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        id_stall = 1'b0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, " branch_cnt"}, branch_cnt, bc);
        chk({tag, " mispredict_cnt"}, mispredict_cnt, mc);
        chk({tag, " upd_drop_cnt"}, upd_drop_cnt, dc);
    endtask

    initial begin
        //          op     rs            rt     pc4           imm      pr idx  cond tkn redir pc
        vecs[0] = '{6'd4, 32'd5,        32'd5, 32'h100,      16'h0004, 1'b0, 6'd3,  1, 1, 1, 32'h110};
        vecs[1] = '{6'd5, 32'd7,        32'd7, 32'h200,      16'h0008, 1'b1, 6'd5,  1, 0, 1, 32'h200};
        vecs[2] = '{6'd7, 32'h80000000, 32'd0, 32'h240,      16'h0010, 1'b0, 6'd7,  1, 0, 0, 32'h200};
        vecs[3] = '{6'd7, 32'd1,        32'd0, 32'h280,      16'h0010, 1'b1, 6'd8,  1, 1, 0, 32'h200};
        vecs[4] = '{6'd7, 32'd0,        32'd0, 32'h300,      16'h0010, 1'b1, 6'd9,  1, 0, 1, 32'h300};
        vecs[5] = '{6'd4, 32'd0,        32'd0, 32'h4,        16'hFFFE, 1'b0, 6'd10, 1, 1, 1, 32'hFFFFFFFC};
        vecs[6] = '{6'd2, 32'd1,        32'd2, 32'h400,      16'h0020, 1'b1, 6'd11, 0, 0, 0, 32'hFFFFFFFC};
        vecs[7] = '{6'd5, 32'd1,        32'd2, 32'h1000,     16'h7FFF, 1'b0, 6'd12, 1, 1, 1, 32'h20FFC};
        vecs[8] = '{6'd6, 32'd0,        32'd0, 32'h500,      16'h0004, 1'b1, 6'd13, 0, 0, 0, 32'h20FFC};
        vecs[9] = '{6'd4, 32'd1,        32'd2, 32'h600,      16'h0004, 1'b0, 6'd14, 1, 0, 0, 32'h20FFC};

        rst_n = 1'b0;
        upd_ready = 1'b1;
        idle();
        drive(6'd0, 0, 0, 0, 0, 1'b0, 6'd0);
        id_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset redirect_valid", {31'd0, redirect_valid}, 0);
        chk("reset flush", {31'd0, flush}, 0);
        chk("reset redirect_pc", redirect_pc, 0);
        chk("reset upd_valid", {31'd0, upd_valid}, 0);
        chk_counts("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table: one instruction, then observe cycle N+1 and N+2.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].pc4, vecs[i].imm,
                  vecs[i].pred, vecs[i].idx);
            @(negedge clk);
            idle();
            if (vecs[i].cond) bc++;
            if (vecs[i].redir) mc++;
            chk($sformatf("v%0d redirect_valid", i), {31'd0, redirect_valid}, {31'd0, vecs[i].redir});
            chk($sformatf("v%0d flush", i), {31'd0, flush}, {31'd0, vecs[i].redir});
            chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].pc);
            chk($sformatf("v%0d upd_valid", i), {31'd0, upd_valid}, {31'd0, vecs[i].cond});
            if (vecs[i].cond) begin
                chk($sformatf("v%0d upd_idx", i), {26'd0, upd_idx}, {26'd0, vecs[i].idx});
                chk($sformatf("v%0d upd_taken", i), {31'd0, upd_taken}, {31'd0, vecs[i].taken});
            end
            chk_counts($sformatf("v%0d", i));
            @(negedge clk);
            chk($sformatf("v%0d pulse end", i), {31'd0, redirect_valid}, 0);
            chk($sformatf("v%0d fifo drained", i), {31'd0, upd_valid}, 0);
        end
        last_pc = 32'h20FFC;

        // Instruction in ID during the flush cycle is ignored.
        drive(6'd4, 32'd5, 32'd5, 32'h4, 16'hFFFE, 1'b0, 6'd20);
        @(negedge clk);
        bc++; mc++;
        chk("shadow first redirect", {31'd0, flush}, 1);
        chk("shadow first pc", redirect_pc, 32'hFFFFFFFC);
        drive(6'd5, 32'd1, 32'd2, 32'h800, 16'h0040, 1'b0, 6'd21);
        @(negedge clk);
        idle();
        chk("shadow no redirect", {31'd0, redirect_valid}, 0);
        chk("shadow pc held", redirect_pc, 32'hFFFFFFFC);
        chk("shadow no update", {31'd0, upd_valid}, 0);
        chk_counts("shadow");

        // Stalled instruction is not consumed.
        id_stall = 1'b1;
        drive(6'd5, 32'd1, 32'd2, 32'h900, 16'h0040, 1'b0, 6'd22);
        repeat (2) @(negedge clk);
        idle();
        chk("stall no redirect", {31'd0, redirect_valid}, 0);
        chk("stall no update", {31'd0, upd_valid}, 0);
        chk_counts("stall");

        // FIFO fills, third entry dropped, then drains in order.
        upd_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(6'd4, 32'd9, 32'd9, 32'h100, 16'h0001, 1'b1, k[5:0]);
            @(negedge clk);
        end
        idle();
        bc += 3; dc++;
        chk("full head idx", {26'd0, upd_idx}, 1);
        chk("full head taken", {31'd0, upd_taken}, 1);
        chk_counts("full");
        @(negedge clk);
        chk("full head stable", {26'd0, upd_idx}, 1);
        chk("full valid stable", {31'd0, upd_valid}, 1);
        upd_ready = 1'b1;
        #1;
        chk("drain idx1", {26'd0, upd_idx}, 1);
        @(negedge clk);
        chk("drain idx2", {26'd0, upd_idx}, 2);
        chk("drain valid2", {31'd0, upd_valid}, 1);
        @(negedge clk);
        chk("drain empty", {31'd0, upd_valid}, 0);

        // Full FIFO with a same-cycle dequeue accepts the new entry.
        upd_ready = 1'b0;
        drive(6'd4, 32'd9, 32'd9, 32'h100, 16'h0001, 1'b1, 6'd4);
        @(negedge clk);
        drive(6'd5, 32'd9, 32'd8, 32'h100, 16'h0001, 1'b1, 6'd5);
        @(negedge clk);
        drive(6'd4, 32'd9, 32'd8, 32'h100, 16'h0001, 1'b0, 6'd6);
        upd_ready = 1'b1;
        @(negedge clk);
        idle();
        bc += 3;
        chk("fulldeq head idx5", {26'd0, upd_idx}, 5);
        chk_counts("fulldeq");
        @(negedge clk);
        chk("fulldeq head idx6", {26'd0, upd_idx}, 6);
        chk("fulldeq taken6", {31'd0, upd_taken}, 0);
        @(negedge clk);
        chk("fulldeq empty", {31'd0, upd_valid}, 0);

        chk("sat branch_cnt", {30'd0, s_branch_cnt}, (bc > 3) ? 3 : bc);
        chk("sat mispredict_cnt", {30'd0, s_mispredict_cnt}, (mc > 3) ? 3 : mc);

        // Reset during a redirect cycle with the FIFO occupied.
        upd_ready = 1'b0;
        drive(6'd4, 32'd5, 32'd5, 32'h100, 16'h0004, 1'b0, 6'd30);
        @(negedge clk);
        idle();
        chk("pre-reset redirect", {31'd0, redirect_valid}, 1);
        chk("pre-reset upd_valid", {31'd0, upd_valid}, 1);
        rst_n = 1'b0;
        #1;
        bc = 0; mc = 0; dc = 0;
        chk("mid reset redirect_valid", {31'd0, redirect_valid}, 0);
        chk("mid reset flush", {31'd0, flush}, 0);
        chk("mid reset redirect_pc", redirect_pc, 0);
        chk("mid reset upd_valid", {31'd0, upd_valid}, 0);
        chk("mid reset upd_idx", {26'd0, upd_idx}, 0);
        chk_counts("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        upd_ready = 1'b1;

        // Jump has no effect on anything.
        drive(6'd2, 32'd5, 32'd5, 32'h100, 16'h0004, 1'b0, 6'd31);
        @(negedge clk);
        idle();
        chk("j redirect_valid", {31'd0, redirect_valid}, 0);
        chk("j redirect_pc", redirect_pc, 0);
        chk("j upd_valid", {31'd0, upd_valid}, 0);
        chk_counts("j");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
